// File: rtl/space_pkg.sv
// Shared constants, FSM encoding and span helper for the space-shooter obstacle formation.
package space_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  localparam logic [2:0] CLR_NONE  = 3'b000;
  localparam logic [2:0] CLR_OBS   = 3'b011;
  localparam logic [2:0] CLR_CRACK = 3'b110;

  typedef enum logic [1:0] {
    ST_MOVE_R = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALT   = 2'd3
  } obs_state_e;

  // Half-open interval test: lo <= v < hi
  function automatic logic in_span(input logic [12:0] v, input logic [12:0] lo,
                                   input logic [12:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/obs_formation_cell.sv
// obs_cell: one obstacle's box compare (pixel and bullet probe) plus alive/cracked flags.
// Build option OBS_SHIELD_EN: the first strike only cracks the obstacle.
module obs_cell
  import space_pkg::*;
#(
  parameter int unsigned OBS_W = 60,
  parameter int unsigned OBS_H = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_left,
  input  logic [10:0] i_top,
  input  logic [10:0] i_pix_x,
  input  logic [10:0] i_pix_y,
  input  logic [10:0] i_hit_x,
  input  logic [10:0] i_hit_y,
  input  logic        i_strike,
  output logic        o_pix_in,
  output logic        o_probe_in,
  output logic        o_alive,
  output logic        o_cracked
);

  logic        r_alive;
  logic        r_cracked;
  logic [12:0] w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic        w_pix_box, w_hit_box;

  assign w_x_lo = {1'b0, i_left};
  assign w_x_hi = w_x_lo + 13'(OBS_W);
  assign w_y_lo = {2'b00, i_top};
  assign w_y_hi = w_y_lo + 13'(OBS_H);

  assign w_pix_box = in_span({2'b00, i_pix_x}, w_x_lo, w_x_hi) &&
                     in_span({2'b00, i_pix_y}, w_y_lo, w_y_hi);
  assign w_hit_box = in_span({2'b00, i_hit_x}, w_x_lo, w_x_hi) &&
                     in_span({2'b00, i_hit_y}, w_y_lo, w_y_hi);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alive   <= 1'b1;
      r_cracked <= 1'b0;
    end else if (i_strike) begin
`ifdef OBS_SHIELD_EN
      if (r_cracked) r_alive <= 1'b0;
      else           r_cracked <= 1'b1;
`else
      r_alive <= 1'b0;
`endif
    end
  end

  assign o_pix_in   = r_alive && w_pix_box;
  assign o_probe_in = r_alive && w_hit_box;
  assign o_alive    = r_alive;
  assign o_cracked  = r_cracked;

endmodule

// File: rtl/obs_formation.sv
// obs_formation: row of N_OBS obstacles that sweeps and drops, with bullet-hit arbitration and registered render.
// Build option OBS_SHIELD_EN: two hits per obstacle, cracked obstacles drawn in CLR_CRACK.
module obs_formation
  import space_pkg::*;
#(
  parameter int unsigned N_OBS     = 8,
  parameter int unsigned OBS_W     = 60,
  parameter int unsigned OBS_H     = 20,
  parameter int unsigned OBS_GAP   = 20,
  parameter int unsigned X0        = 20,
  parameter int unsigned Y0        = 20,
  parameter int unsigned STEP_DX   = 2,
  parameter int unsigned STEP_DY   = 10,
  parameter int unsigned FRAME_DIV = 2,
  parameter int unsigned Y_LIMIT   = 400,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               video_on,
  input  logic [10:0]        pix_x,
  input  logic [10:0]        pix_y,
  input  logic               frame_tick,
  input  logic               hit_valid,
  input  logic [10:0]        hit_x,
  input  logic [10:0]        hit_y,
  output logic               hit_ack,
  output logic               obs_on,
  output logic [2:0]         rgb,
  output logic [N_OBS-1:0]   alive,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               all_clear
);

  localparam int unsigned PITCH = OBS_W + OBS_GAP;
  localparam int unsigned FC_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  obs_state_e         r_state;
  logic               r_dir_left;
  logic [10:0]        r_off_x, r_off_y;
  logic [FC_W-1:0]    r_fcnt;
  logic               r_hit_busy, r_hit_ack;
  logic               r_obs_on, r_game_over, r_all_clear;
  logic [2:0]         r_rgb;
  logic [SCORE_W-1:0] r_score;

  logic [11:0]        w_left [N_OBS];
  logic [N_OBS-1:0]   w_alive, w_cracked, w_pix, w_probe, w_strike;
  logic [11:0]        w_lo_left, w_hi_left;
  logic [12:0]        w_hi_reach;
  logic [10:0]        w_next_y;
  logic               w_move_tick, w_accept, w_hit;

  for (genvar g = 0; g < N_OBS; g++) begin : g_cell
    assign w_left[g] = {1'b0, r_off_x} + 12'(g * PITCH);
    obs_cell #(.OBS_W(OBS_W), .OBS_H(OBS_H)) u_cell (
      .i_clk      (clk),
      .i_rst_n    (reset_n),
      .i_left     (w_left[g]),
      .i_top      (r_off_y),
      .i_pix_x    (pix_x),
      .i_pix_y    (pix_y),
      .i_hit_x    (hit_x),
      .i_hit_y    (hit_y),
      .i_strike   (w_strike[g]),
      .o_pix_in   (w_pix[g]),
      .o_probe_in (w_probe[g]),
      .o_alive    (w_alive[g]),
      .o_cracked  (w_cracked[g])
    );
  end

  // Edge tests only consider surviving obstacles, so a thinned row sweeps further.
  always_comb begin
    w_lo_left = '0;
    w_hi_left = '0;
    for (int unsigned i = 0; i < N_OBS; i++)
      if (w_alive[i]) w_hi_left = w_left[i];
    for (int unsigned i = N_OBS; i > 0; i--)
      if (w_alive[i-1]) w_lo_left = w_left[i-1];
  end

  assign w_hi_reach  = {1'b0, w_hi_left} + 13'(OBS_W + STEP_DX);
  assign w_next_y    = r_off_y + 11'(STEP_DY);
  assign w_move_tick = frame_tick && (r_fcnt == FC_W'(FRAME_DIV - 1));
  assign w_accept    = hit_valid && (r_state != ST_HALT) && !r_hit_busy;
  assign w_strike    = w_accept ? (w_probe & (~w_probe + N_OBS'(1))) : '0;
  assign w_hit       = |w_strike;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_MOVE_R;
      r_dir_left  <= 1'b0;
      r_off_x     <= 11'(X0);
      r_off_y     <= 11'(Y0);
      r_fcnt      <= '0;
      r_game_over <= 1'b0;
    end else begin
      if (frame_tick) r_fcnt <= w_move_tick ? '0 : r_fcnt + 1'b1;
      if (w_alive == '0) begin
        r_state <= ST_HALT;
      end else if (w_move_tick) begin
        unique case (r_state)
          ST_MOVE_R: begin
            if (w_hi_reach > 13'(H_RES)) begin
              r_state    <= ST_DROP;
              r_dir_left <= 1'b1;
            end else begin
              r_off_x <= r_off_x + 11'(STEP_DX);
            end
          end
          ST_MOVE_L: begin
            if (w_lo_left < 12'(STEP_DX)) begin
              r_state    <= ST_DROP;
              r_dir_left <= 1'b0;
            end else begin
              r_off_x <= r_off_x - 11'(STEP_DX);
            end
          end
          ST_DROP: begin
            r_off_y <= w_next_y;
            if (({1'b0, w_next_y} + 12'(OBS_H)) >= 12'(Y_LIMIT)) begin
              r_state     <= ST_HALT;
              r_game_over <= 1'b1;
            end else begin
              r_state <= r_dir_left ? ST_MOVE_L : ST_MOVE_R;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_busy  <= 1'b0;
      r_hit_ack   <= 1'b0;
      r_score     <= '0;
      r_all_clear <= 1'b0;
      r_obs_on    <= 1'b0;
      r_rgb       <= CLR_NONE;
    end else begin
      r_hit_busy  <= w_accept;
      r_hit_ack   <= w_hit;
      if (w_hit && (r_score != '1)) r_score <= r_score + 1'b1;
      r_all_clear <= r_all_clear || (w_alive == '0);
      r_obs_on    <= video_on && (|w_pix);
      if (video_on && (|w_pix))
        r_rgb <= (|(w_pix & w_cracked)) ? CLR_CRACK : CLR_OBS;
      else
        r_rgb <= CLR_NONE;
    end
  end

  assign hit_ack   = r_hit_ack;
  assign obs_on    = r_obs_on;
  assign rgb       = r_rgb;
  assign alive     = w_alive;
  assign score     = r_score;
  assign game_over = r_game_over;
  assign all_clear = r_all_clear;

endmodule

// File: tb/tb_obs_formation.sv
// Directed bench for obs_formation: render/probe tables plus sweep, drop, halt and async-reset sequences.
module tb_obs_formation;

  logic        clk = 1'b0;
  logic        reset_n, video_on, frame_tick, hit_valid;
  logic [10:0] pix_x, pix_y, hit_x, hit_y;
  logic        hit_ack, obs_on, game_over, all_clear;
  logic [2:0]  rgb;
  logic [7:0]  alive, score;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  obs_formation #(
    .N_OBS(8), .OBS_W(60), .OBS_H(20), .OBS_GAP(20), .X0(20), .Y0(20),
    .STEP_DX(2), .STEP_DY(10), .FRAME_DIV(2), .Y_LIMIT(400), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ack(hit_ack), .obs_on(obs_on), .rgb(rgb), .alive(alive), .score(score),
    .game_over(game_over), .all_clear(all_clear)
  );

  typedef struct {
    logic       vo;
    int         x;
    int         y;
    logic       on;
    logic [2:0] c;
  } rvec_t;

  typedef struct {
    logic       vo;
    int         x;
    int         y;
    logic       ack;
    logic [7:0] sc;
    logic [7:0] al;
  } pvec_t;

  rvec_t rtab[10];
  pvec_t ptab[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic render(input logic vo, input int x, input int y, input logic on,
                        input logic [2:0] c, input string nm);
    video_on = vo;
    pix_x    = 11'(x);
    pix_y    = 11'(y);
    step();
    chk({nm, " obs_on"}, 32'(obs_on), 32'(on));
    chk({nm, " rgb"}, 32'(rgb), 32'(c));
  endtask

  task automatic probe(input logic vo, input int x, input int y, input logic ack,
                       input string nm);
    video_on  = vo;
    hit_valid = 1'b1;
    hit_x     = 11'(x);
    hit_y     = 11'(y);
    step();
    hit_valid = 1'b0;
    chk({nm, " hit_ack"}, 32'(hit_ack), 32'(ack));
    step();
    chk({nm, " hit_ack pulse end"}, 32'(hit_ack), 32'd0);
  endtask

  task automatic ftick(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic left_edge(input int x, input int y, input string nm);
    render(1'b1, x - 1, y, 1'b0, 3'b000, {nm, " left-1"});
    render(1'b1, x, y, 1'b1, 3'b011, {nm, " left"});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0; video_on = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0;
    pix_x = '0; pix_y = '0; hit_x = '0; hit_y = '0;

    rtab[0] = '{1'b1, 20,  20, 1'b1, 3'b011};
    rtab[1] = '{1'b1, 80,  20, 1'b0, 3'b000};
    rtab[2] = '{1'b1, 79,  39, 1'b1, 3'b011};
    rtab[3] = '{1'b1, 79,  40, 1'b0, 3'b000};
    rtab[4] = '{1'b1, 19,  20, 1'b0, 3'b000};
    rtab[5] = '{1'b1, 20,  19, 1'b0, 3'b000};
    rtab[6] = '{1'b1, 100, 20, 1'b1, 3'b011};
    rtab[7] = '{1'b0, 20,  20, 1'b0, 3'b000};
    rtab[8] = '{1'b1, 639, 20, 1'b1, 3'b011};
    rtab[9] = '{1'b1, 640, 20, 1'b0, 3'b000};

    ptab[0] = '{1'b1, 85,  25, 1'b0, 8'd0, 8'hFF};
    ptab[1] = '{1'b0, 25,  25, 1'b1, 8'd1, 8'hFE};
    ptab[2] = '{1'b1, 25,  25, 1'b0, 8'd1, 8'hFE};
    ptab[3] = '{1'b1, 105, 25, 1'b1, 8'd2, 8'hFC};
    ptab[4] = '{1'b1, 185, 19, 1'b0, 8'd2, 8'hFC};
    ptab[5] = '{1'b1, 185, 39, 1'b1, 8'd3, 8'hF8};
    ptab[6] = '{1'b1, 570, 25, 1'b0, 8'd3, 8'hF8};
    ptab[7] = '{1'b1, 639, 25, 1'b1, 8'd4, 8'h78};

    step();
    chk("reset alive", 32'(alive), 32'hFF);
    chk("reset score", 32'(score), 32'd0);
    chk("reset game_over", 32'(game_over), 32'd0);
    chk("reset all_clear", 32'(all_clear), 32'd0);
    chk("reset hit_ack", 32'(hit_ack), 32'd0);
    chk("reset obs_on", 32'(obs_on), 32'd0);
    reset_n = 1'b1;
    step();

`ifdef OBS_SHIELD_EN
    probe(1'b1, 185, 25, 1'b1, "shield first");
    chk("shield first score", 32'(score), 32'd1);
    chk("shield first alive", 32'(alive), 32'hFF);
    render(1'b1, 185, 25, 1'b1, 3'b110, "shield cracked");
    render(1'b1, 265, 25, 1'b1, 3'b011, "shield intact");
    probe(1'b1, 185, 25, 1'b1, "shield second");
    chk("shield second score", 32'(score), 32'd2);
    chk("shield second alive", 32'(alive), 32'hFB);
    render(1'b1, 185, 25, 1'b0, 3'b000, "shield cleared");
`else
    for (int i = 0; i < 10; i++)
      render(rtab[i].vo, rtab[i].x, rtab[i].y, rtab[i].on, rtab[i].c, $sformatf("render[%0d]", i));

    for (int i = 0; i < 8; i++) begin
      probe(ptab[i].vo, ptab[i].x, ptab[i].y, ptab[i].ack, $sformatf("probe[%0d]", i));
      chk($sformatf("probe[%0d] score", i), 32'(score), 32'(ptab[i].sc));
      chk($sformatf("probe[%0d] alive", i), 32'(alive), 32'(ptab[i].al));
    end
    render(1'b1, 25,  25, 1'b0, 3'b000, "cleared obs0");
    render(1'b1, 105, 25, 1'b0, 3'b000, "cleared obs1");
    render(1'b1, 265, 25, 1'b1, 3'b011, "intact obs3");

    // Back-to-back probes: the second lands while the first is in flight.
    video_on = 1'b1; hit_valid = 1'b1; hit_x = 11'd265; hit_y = 11'd25;
    step();
    chk("inflight first ack", 32'(hit_ack), 32'd1);
    hit_x = 11'd345;
    step();
    hit_valid = 1'b0;
    chk("inflight second ack", 32'(hit_ack), 32'd0);
    step();
    chk("inflight alive", 32'(alive), 32'h70);
    chk("inflight score", 32'(score), 32'd5);

    // Lone obstacle 0 sweeps right until its right edge reaches 640.
    do_reset();
    for (int i = 1; i < 8; i++) probe(1'b1, 25 + 80 * i, 25, 1'b1, $sformatf("clear obs%0d", i));
    chk("cleared alive", 32'(alive), 32'h01);
    chk("cleared score", 32'(score), 32'd7);
    ftick(1);
    left_edge(20, 20, "tick1");
    ftick(1);
    left_edge(22, 20, "tick2");
    ftick(1);
    left_edge(22, 20, "tick3");
    ftick(1);
    left_edge(24, 20, "tick4");
    ftick(556);
    left_edge(580, 20, "sweep end");
    render(1'b1, 639, 20, 1'b1, 3'b011, "sweep end right");
    ftick(2);
    left_edge(580, 20, "drop enter x");
    render(1'b1, 580, 19, 1'b0, 3'b000, "drop enter y-1");
    ftick(2);
    render(1'b1, 580, 29, 1'b0, 3'b000, "dropped y-1");
    left_edge(580, 30, "dropped");
    ftick(2);
    left_edge(578, 30, "move left");

    probe(1'b1, 583, 35, 1'b1, "last obstacle");
    chk("all clear alive", 32'(alive), 32'h00);
    chk("all clear score", 32'(score), 32'd8);
    chk("all_clear flag", 32'(all_clear), 32'd1);
    chk("all clear game_over", 32'(game_over), 32'd0);
    probe(1'b1, 583, 35, 1'b0, "probe after clear");
    chk("after clear score", 32'(score), 32'd8);

    // Full row: 422 move ticks (844 frame ticks) to reach off_y=380 and halt.
    do_reset();
    ftick(843);
    chk("pre halt game_over", 32'(game_over), 32'd0);
    ftick(1);
    chk("halt game_over", 32'(game_over), 32'd1);
    render(1'b1, 0,  379, 1'b0, 3'b000, "halt top-1");
    render(1'b1, 0,  380, 1'b1, 3'b011, "halt top");
    render(1'b1, 0,  399, 1'b1, 3'b011, "halt bottom");
    render(1'b1, 0,  400, 1'b0, 3'b000, "halt bottom+1");
    render(1'b1, 59, 380, 1'b1, 3'b011, "halt obs0 right");
    render(1'b1, 60, 380, 1'b0, 3'b000, "halt gap");
    render(1'b1, 80, 380, 1'b1, 3'b011, "halt obs1");
    ftick(4);
    render(1'b1, 0, 379, 1'b0, 3'b000, "frozen top-1");
    probe(1'b1, 5, 385, 1'b0, "halt probe");
    chk("halt score", 32'(score), 32'd0);
    render(1'b1, 0, 380, 1'b1, 3'b011, "frozen top");

    #3;
    reset_n = 1'b0;
    #1;
    chk("async obs_on", 32'(obs_on), 32'd0);
    chk("async rgb", 32'(rgb), 32'd0);
    chk("async game_over", 32'(game_over), 32'd0);
    chk("async alive", 32'(alive), 32'hFF);
    step();
    reset_n = 1'b1;
    step();
    left_edge(20, 20, "post reset");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
